ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (0xED LED set, 0xF4 enable, 0xFF reset, 0xFE resend).
- Pairs with the existing keyboard receive path: same PS2_CLK/PS2_DAT pins, opposite direction.
- Drives the open-drain lines through output enables; the top level ties PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz, and likewise for DAT.
- `busy` tells the receive path to ignore the bus while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, error codes,
// keyboard command bytes and the frame length.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      DATA,
      PARITY,
      STOP,
      ACK,
      WAIT_IDLE
   } ps2_tx_state_e;

   localparam logic [1:0] ERR_NONE          = 2'd0;
   localparam logic [1:0] ERR_START_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_FRAME_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_NO_ACK        = 2'd3;

   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] CMD_RESEND  = 8'hFE;

   localparam int FRAME_EDGES = 11;

   // Microsecond delays are converted once, so every timer is a plain cycle count.
   function automatic int us_to_cycles(input int freq_hz, input int us);
      return (freq_hz / 1000000) * us;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
interface ps2_host_tx_if;

   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_err;
   logic [1:0] err_code;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, busy, tx_done, tx_err, err_code
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, busy, tx_done, tx_err, err_code
   );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 pins plus clock falling-edge detect;
// the receive path can reuse it unchanged.
module ps2_line_sync (
   input  logic Clock,
   input  logic reset,
   input  logic clk_in,
   input  logic dat_in,
   output logic clk_sync,
   output logic dat_sync,
   output logic clk_fall
);

   logic [1:0] clk_pipe;
   logic [1:0] dat_pipe;
   logic       clk_prev;

   // Reset to the idle-high bus level so no phantom edge appears after reset.
   always_ff @(posedge Clock) begin
      if (reset) begin
         clk_pipe <= 2'b11;
         dat_pipe <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_pipe <= {clk_pipe[0], clk_in};
         dat_pipe <= {dat_pipe[0], dat_in};
         clk_prev <= clk_pipe[1];
      end
   end

   assign clk_sync = clk_pipe[1];
   assign dat_sync = dat_pipe[1];
   assign clk_fall = clk_prev & ~clk_pipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device-generated clock edges.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLOCK_FREQUENCY  = 25000000,
   parameter int INHIBIT_US       = 120,
   parameter int START_TIMEOUT_US = 15000,
   parameter int FRAME_TIMEOUT_US = 2000
) (
   input  logic          Clock,
   input  logic          reset,
   ps2_host_tx_if.slave  cmd,
   input  logic          ps2_clk_in,
   input  logic          ps2_dat_in,
   output logic          ps2_clk_oe,
   output logic          ps2_dat_oe
);

   localparam int INHIBIT_CYCLES = us_to_cycles(CLOCK_FREQUENCY, INHIBIT_US);
   localparam int START_CYCLES   = us_to_cycles(CLOCK_FREQUENCY, START_TIMEOUT_US);
   localparam int FRAME_CYCLES   = us_to_cycles(CLOCK_FREQUENCY, FRAME_TIMEOUT_US);
   localparam int TIMER_MAX      = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
   localparam int TW             = $clog2(TIMER_MAX + 1);
   localparam int FW             = $clog2(FRAME_CYCLES + 1);

   localparam logic [TW-1:0] INHIBIT_LAST   = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] START_LAST     = TW'(START_CYCLES - 1);
   localparam logic [FW-1:0] FRAME_LAST     = FW'(FRAME_CYCLES - 1);
   localparam logic [3:0]    LAST_DATA_EDGE = 4'(FRAME_EDGES - 3);

   ps2_tx_state_e state, next_state;

   logic [TW-1:0] timer;
   logic [FW-1:0] frame_timer;
   logic [3:0]    edge_cnt;
   logic [7:0]    data_q;
   logic          parity_q;
   logic          drive_q;
   logic          ack_ok_q;
   logic [1:0]    err_code_q;
   logic          done_q;
   logic          err_q;
   logic          ready_en;

   logic clk_sync, dat_sync, clk_fall;
   logic tx_ready_w, accept;
   logic inhibit_end, start_expired, frame_expired, in_frame, bus_idle;

   ps2_line_sync u_sync (
      .Clock    (Clock),
      .reset    (reset),
      .clk_in   (ps2_clk_in),
      .dat_in   (ps2_dat_in),
      .clk_sync (clk_sync),
      .dat_sync (dat_sync),
      .clk_fall (clk_fall)
   );

   assign tx_ready_w    = (state == IDLE) && ready_en;
   assign accept        = cmd.tx_valid && tx_ready_w;
   assign inhibit_end   = (timer == INHIBIT_LAST);
   assign start_expired = (timer == START_LAST);
   assign frame_expired = (frame_timer == FRAME_LAST);
   assign in_frame      = state inside {DATA, PARITY, STOP, ACK, WAIT_IDLE};
   assign bus_idle      = clk_sync && dat_sync;

   always_ff @(posedge Clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Frame timeout is checked before any edge so it wins a tie.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = INHIBIT;
         INHIBIT: if (inhibit_end) next_state = REQ;
         REQ: begin
            if (clk_fall)           next_state = DATA;
            else if (start_expired) next_state = IDLE;
         end
         default: begin
            if (frame_expired) begin
               next_state = IDLE;
            end else begin
               case (state)
                  DATA:      if (clk_fall && edge_cnt == LAST_DATA_EDGE) next_state = PARITY;
                  PARITY:    if (clk_fall) next_state = STOP;
                  STOP:      if (clk_fall) next_state = ACK;
                  ACK:       next_state = WAIT_IDLE;
                  WAIT_IDLE: if (bus_idle) next_state = IDLE;
                  default:   next_state = IDLE;
               endcase
            end
         end
      endcase
   end

   // Datapath: timers, bit selection on each device edge, and result flags.
   always_ff @(posedge Clock) begin
      if (reset) begin
         timer       <= '0;
         frame_timer <= '0;
         edge_cnt    <= '0;
         data_q      <= '0;
         parity_q    <= 1'b0;
         drive_q     <= 1'b0;
         ack_ok_q    <= 1'b0;
         err_code_q  <= ERR_NONE;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ready_en    <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         case (state)
            IDLE: begin
               timer       <= '0;
               frame_timer <= '0;
               edge_cnt    <= '0;
               if (accept) begin
                  data_q     <= cmd.tx_data;
                  parity_q   <= ~^cmd.tx_data;
                  err_code_q <= ERR_NONE;
               end
            end
            INHIBIT: timer <= inhibit_end ? '0 : timer + 1'b1;
            REQ: begin
               timer <= timer + 1'b1;
               if (clk_fall) begin
                  drive_q     <= ~data_q[0];
                  edge_cnt    <= 4'd1;
                  frame_timer <= FW'(1);
               end else if (start_expired) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_START_TIMEOUT;
               end
            end
            default: begin
               frame_timer <= frame_timer + 1'b1;
               if (frame_expired) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_FRAME_TIMEOUT;
               end else begin
                  if (clk_fall && state inside {DATA, PARITY, STOP}) edge_cnt <= edge_cnt + 4'd1;
                  case (state)
                     DATA: if (clk_fall) drive_q <= (edge_cnt == LAST_DATA_EDGE) ? ~parity_q
                                                                                : ~data_q[edge_cnt[2:0]];
                     PARITY: if (clk_fall) drive_q <= 1'b0;
                     STOP: if (clk_fall) begin
                        ack_ok_q <= ~dat_sync;
                        if (dat_sync) err_code_q <= ERR_NO_ACK;
                     end
                     WAIT_IDLE: if (bus_idle) begin
                        done_q <= ack_ok_q;
                        err_q  <= ~ack_ok_q;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   always_comb begin
      ps2_clk_oe = (state == INHIBIT);
      ps2_dat_oe = 1'b0;
      if (state == INHIBIT && inhibit_end)             ps2_dat_oe = 1'b1;
      else if (state == REQ)                           ps2_dat_oe = 1'b1;
      else if ((state == DATA || state == PARITY) && in_frame) ps2_dat_oe = drive_q;
   end

   assign cmd.tx_ready = tx_ready_w;
   assign cmd.busy     = (state != IDLE);
   assign cmd.tx_done  = done_q;
   assign cmd.tx_err   = err_q;
   assign cmd.err_code = err_code_q;

endmodule
